// File: rtl/lmc_pkg.sv
// Shared definitions for the LMC program-counter/program-memory slice:
// run-controller state encoding and branch opcode encoding.
package lmc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BRA     = 2'b01;
  localparam logic [1:0] BRZ     = 2'b10;
  localparam logic [1:0] BRP     = 2'b11;

endpackage : lmc_pkg

// File: rtl/lmc_ram.sv
// Program store: DATA_W x 2**ADDR_W words, synchronous write, asynchronous read.
module lmc_ram #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage arrays carry no reset; clearing them costs a reset net to
  // every bit and forbids mapping onto RAM primitives. Contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule : lmc_ram

// File: rtl/lmc_pc_mem.sv
// LMC program counter, three-state run controller and program memory.
// Optional branching is compiled in with `define LMC_BRANCH_EN.
module lmc_pc_mem
  import lmc_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
) (
  input  logic              timer555,
  input  logic              reset_n,
  input  logic              run,
  input  logic              halt,
  input  logic              Counter_load,
  input  logic              RAM_button,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        br_op,
  input  logic              br_zero,
  input  logic              br_pos,
  output logic [ADDR_W-1:0] counter,
  output logic [DATA_W-1:0] RAM_out,
  output logic [1:0]        state,
  output logic              wrap
);

  localparam logic [ADDR_W-1:0] PC_LAST = {ADDR_W{1'b1}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              wrap_d;
  logic              run_step;
  logic              br_taken;
  logic [ADDR_W-1:0] target;

  assign target   = data_in[ADDR_W-1:0];
  // The halt edge freezes the counter, so stepping requires halt low.
  assign run_step = (state_q == RUN) && !halt;

`ifdef LMC_BRANCH_EN
  always_comb begin
    br_taken = 1'b0;
    case (br_op)
      BRA:     br_taken = 1'b1;
      BRZ:     br_taken = br_zero;
      BRP:     br_taken = br_pos;
      default: br_taken = 1'b0;
    endcase
  end
`else
  logic unused_br;
  assign br_taken  = 1'b0;
  assign unused_br = ^{br_op, br_zero, br_pos};
`endif

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run)  state_d = RUN;
      RUN:     if (halt) state_d = HALT;
      HALT:    if (!run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load wins in any state; branches and increments only while stepping.
  always_comb begin
    pc_d   = pc_q;
    wrap_d = 1'b0;
    if (Counter_load) begin
      pc_d = target;
    end else if (run_step && br_taken) begin
      pc_d = target;
    end else if (run_step) begin
      pc_d   = pc_q + ADDR_W'(1);
      wrap_d = (pc_q == PC_LAST);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge timer555 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wrap    <= wrap_d;
    end
  end

  assign counter = pc_q;
  assign state   = state_q;

  // Writes land at the pre-edge counter even when a load moves it.
  lmc_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (timer555),
    .we    (RAM_button),
    .addr  (pc_q),
    .wdata (data_in),
    .rdata (RAM_out)
  );

endmodule : lmc_pc_mem

// File: tb/tb_lmc_pc_mem.sv
// Self-checking bench for lmc_pc_mem: behavioural model compared every cycle,
// directed literal checks, then randomized stimulus.
module tb_lmc_pc_mem;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              run, halt, Counter_load, RAM_button;
  logic [DATA_W-1:0] data_in;
  logic [1:0]        br_op;
  logic              br_zero, br_pos;
  logic [ADDR_W-1:0] counter;
  logic [DATA_W-1:0] RAM_out;
  logic [1:0]        state;
  logic              wrap;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lmc_pc_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .timer555     (clk),
    .reset_n      (reset_n),
    .run          (run),
    .halt         (halt),
    .Counter_load (Counter_load),
    .RAM_button   (RAM_button),
    .data_in      (data_in),
    .br_op        (br_op),
    .br_zero      (br_zero),
    .br_pos       (br_pos),
    .counter      (counter),
    .RAM_out      (RAM_out),
    .state        (state),
    .wrap         (wrap)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: states as 0=idle 1=run 2=halt, memory with valid bits.
  int                m_pc   = 0;
  int                m_st   = 0;
  bit                m_wrap = 1'b0;
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_vld [DEPTH];

  function automatic bit model_taken(input logic [1:0] op, input logic z, input logic p);
`ifdef LMC_BRANCH_EN
    if (op == 2'd1) return 1'b1;
    if (op == 2'd2) return z;
    if (op == 2'd3) return p;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pc   = 0;
      m_st   = 0;
      m_wrap = 1'b0;
    end else begin
      bit stepping;
      if (RAM_button) begin
        m_mem[m_pc] = data_in;
        m_vld[m_pc] = 1'b1;
      end
      stepping = (m_st == 1) && !halt;
      m_wrap   = 1'b0;
      if (Counter_load)
        m_pc = int'(data_in) % DEPTH;
      else if (stepping && model_taken(br_op, br_zero, br_pos))
        m_pc = int'(data_in) % DEPTH;
      else if (stepping) begin
        m_wrap = (m_pc == DEPTH - 1);
        m_pc   = (m_pc + 1) % DEPTH;
      end
      if (m_st == 0 && run)       m_st = 1;
      else if (m_st == 1 && halt) m_st = 2;
      else if (m_st == 2 && !run) m_st = 0;
    end
  end

  // Outputs are registered or read from the counter, so mid-low-phase is stable.
  always @(negedge clk) begin
    check("counter", 32'(counter), 32'(m_pc));
    check("state",   32'(state),   32'(m_st));
    check("wrap",    32'(wrap),    32'(m_wrap));
    if (m_vld[m_pc]) check("RAM_out", 32'(RAM_out), 32'(m_mem[m_pc]));
  end

  // One clock edge: returns just after the following falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    run = 0; halt = 0; Counter_load = 0; RAM_button = 0;
    data_in = '0; br_op = 2'b00; br_zero = 0; br_pos = 0;
  endtask

  task automatic load_pc(input int a);
    Counter_load = 1; data_in = DATA_W'(a);
    tick();
    Counter_load = 0;
  endtask

  int exp_cnt [6] = '{0, 1, 2, 3, 0, 1};
  int exp_wrp [6] = '{0, 0, 0, 0, 1, 0};

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      run = 1'($urandom); halt = 1'($urandom);
      tick();
      check("rst_counter", 32'(counter), 32'd0);
      check("rst_state",   32'(state),   32'd0);
      check("rst_wrap",    32'(wrap),    32'd0);
    end
    idle_inputs();
    reset_n = 1'b1;
    tick();

    for (int a = 0; a < DEPTH; a++) begin
      load_pc(a);
      RAM_button = 1; data_in = DATA_W'(4'hA + a);
      tick();
      RAM_button = 0;
    end
    for (int a = 0; a < DEPTH; a++) begin
      load_pc(a);
      check("prog_read", 32'(RAM_out), 32'(4'hA + a));
    end

    load_pc(0);
    run = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("run_state", 32'(state),   32'd1);
      check("run_count", 32'(counter), 32'(exp_cnt[i]));
      check("run_wrap",  32'(wrap),    32'(exp_wrp[i]));
    end
    tick();
    check("pre_halt_count", 32'(counter), 32'd2);
    halt = 1;
    tick();
    halt = 0;
    check("halt_state", 32'(state),   32'd2);
    check("halt_count", 32'(counter), 32'd2);
    run = 0;
    tick();
    check("halt_idle", 32'(state),   32'd0);
    check("idle_count", 32'(counter), 32'd2);

    load_pc(1);
    run = 1;
    tick();
    check("br_setup", 32'(counter), 32'd1);
    br_op = 2'b10; br_zero = 1; data_in = 4'd3;
    tick();
`ifdef LMC_BRANCH_EN
    check("brz_taken", 32'(counter), 32'd3);
`else
    check("brz_ignored", 32'(counter), 32'd2);
`endif
    br_op = 2'b11; br_pos = 0; br_zero = 0;
    tick();
`ifdef LMC_BRANCH_EN
    check("brp_not_taken", 32'(counter), 32'd0);
    check("brp_wrap",      32'(wrap),    32'd1);
`else
    check("brp_ignored", 32'(counter), 32'd3);
`endif
    idle_inputs();
    halt = 1; run = 1;
    tick();
    halt = 0; run = 0;
    tick();
    check("br_back_idle", 32'(state), 32'd0);

    load_pc(1);
    Counter_load = 1; RAM_button = 1; data_in = 4'h2;
    tick();
    Counter_load = 0; RAM_button = 0;
    check("ldwr_counter", 32'(counter), 32'd2);
    check("ldwr_other",   32'(RAM_out), 32'hC);
    load_pc(1);
    check("ldwr_mem", 32'(RAM_out), 32'h2);

    load_pc(3);
    run = 1;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("async_counter", 32'(counter), 32'd0);
    check("async_state",   32'(state),   32'd0);
    check("mem_retained",  32'(RAM_out), 32'hA);
    idle_inputs();
    tick();
    reset_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      reset_n      = ($urandom_range(0, 59) != 0);
      run          = ($urandom_range(0, 3) != 0);
      halt         = ($urandom_range(0, 5) == 0);
      Counter_load = ($urandom_range(0, 7) == 0);
      RAM_button   = reset_n && ($urandom_range(0, 4) == 0);
      data_in      = DATA_W'($urandom);
      br_op        = 2'($urandom);
      br_zero      = 1'($urandom);
      br_pos       = 1'($urandom);
      tick();
    end
    reset_n = 1'b1;
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_lmc_pc_mem

// File: doc/lmc_pc_mem.md
# lmc_pc_mem

Parametrised program-counter-plus-program-memory block for the LMC datapath. It holds a 2**ADDR_W-word program store and addresses it with a program counter that can be loaded, incremented and, optionally, branched. A three-state run controller drives the counter. Memory is written at the current counter address for front-panel programming, and read combinationally at that address to feed instruction decode.

## Interface
- ADDR_W, 2: counter/address width; depth = 2**ADDR_W words
- DATA_W, 4: memory word width; must be ≥ ADDR_W
- timer555  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  level; start/continue execution
- halt  in  1  level; stop request while running
- Counter_load  in  1  synchronous counter load from data_in[ADDR_W-1:0]
- RAM_button  in  1  synchronous write enable: mem[counter] <= data_in
- data_in  in  DATA_W  write data / load target
- br_op  in  2  00 none, 01 BRA, 10 BRZ, 11 BRP
- br_zero  in  1  accumulator-zero flag
- br_pos  in  1  accumulator-non-negative flag
- counter  out  ADDR_W  program counter
- RAM_out  out  DATA_W  mem[counter], combinational
- state  out  2  00 IDLE, 01 RUN, 10 HALT
- wrap  out  1  one-cycle pulse when the counter increments from 2**ADDR_W-1 to 0

## Operation
- Reset (async assert, sync-safe release): counter=0, state=IDLE, wrap=0. Memory is not reset and is X until written.
- FSM:
  - IDLE→RUN when run=1.
  - RUN→HALT when halt=1. halt has priority over run.
  - HALT→IDLE when run=0.
  - All other combinations hold.
- Counter next-value priority, evaluated every edge:
  1. Counter_load=1 (any state): counter <= data_in[ADDR_W-1:0].
  2. In RUN with halt=0 and branch taken: counter <= data_in[ADDR_W-1:0].
  3. In RUN with halt=0: counter <= counter+1, modulo 2**ADDR_W.
  4. Otherwise hold.
- Branch taken (RUN only):
  - BRA always.
  - BRZ when br_zero=1.
  - BRP when br_pos=1.
  - br_op=00 never.
- wrap is asserted only on case 3 with counter = all-ones. A load or branch to 0 does not assert wrap.
- RAM_button=1 writes data_in to mem[counter], using the pre-edge counter. This is allowed in any state. Write and load in the same cycle: write goes to the old address, and the counter takes the new value.
- RAM_out always reflects mem[counter]. It shows new data in the cycle after a write to the current address.

## Timing
- Counter, state and wrap are registered. All update one edge after the qualifying inputs.
- Read latency is 0 cycles (combinational from counter). Write latency is 1 edge.
- The step on the RUN-entry edge is still IDLE, so no increment occurs. The first increment happens on the edge after state=RUN.
- The halt edge in RUN does not increment: the counter freezes at its current value as state goes to HALT.
- Reset asserted mid-run: counter and state clear immediately. Memory contents are retained.

## Configuration
- LMC_BRANCH_EN defined: br_op, br_zero and br_pos are evaluated as described.
- LMC_BRANCH_EN undefined: the ports remain, but their values are ignored. A branch is never taken, so the counter only loads, increments or holds.

## Structure
- Shared package lmc_pkg holds:
  - state encoding typedef: IDLE/RUN/HALT
  - br_op encoding constants: BR_NONE/BRA/BRZ/BRP
- One sub-module, lmc_ram: a DATA_W × 2**ADDR_W array with synchronous write and asynchronous read, parametrised identically.
- Counter and FSM logic live in the top module.

## Test plan
- Reset then no stimulus: counter=0, state=IDLE, wrap=0, for any run/halt pattern during reset.
- Program (ADDR_W=2, DATA_W=4): for each address, pulse Counter_load with data_in=a, then RAM_button with data_in=4'hA+a. Then load 0 → RAM_out=A, B, C, D as counter steps 0..3.
- Run with run=1 from IDLE for 6 edges: state=RUN after edge 1; counter 0,1,2,3,0,1 with wrap high exactly on the 3→0 edge.
- In RUN, assert halt at counter=2: state=HALT and counter stays 2. Then drop run: state=IDLE.
- With LMC_BRANCH_EN, RUN at counter=1:
  - br_op=BRZ, br_zero=1, data_in=3 → counter=3.
  - br_op=BRP, br_pos=0 → counter increments.
  - Without the macro, the BRZ case increments to 2.
- Same-cycle Counter_load (data_in=2) and RAM_button at counter=1: mem[1]=4'h2 and counter=2. Then load 1 → RAM_out=4'h2.
